// File: rtl/mult_share_ctrl.sv
// mult_share_ctrl: round-robin front end that lets NREQ requesters share one
// external combinational 16x16 signed multiplier through a two-stage
// (operand register / result register) pipeline with full backpressure.
module mult_share_ctrl #(
  parameter int unsigned NREQ = 4,
  parameter int unsigned IDW  = 2
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [NREQ-1:0]    req_valid,
  output logic [NREQ-1:0]    req_ready,
  input  logic [NREQ*16-1:0] req_a,
  input  logic [NREQ*16-1:0] req_b,
  output logic [15:0]        mul_a,
  output logic [15:0]        mul_b,
  input  logic [31:0]        mul_result,
  output logic               rsp_valid,
  input  logic               rsp_ready,
  output logic [IDW-1:0]     rsp_id,
  output logic [31:0]        rsp_result,
  output logic [15:0]        ops_done
);

  logic           s1_valid;
  logic [IDW-1:0] s1_id;
  logic [IDW-1:0] rr_ptr;
  logic           s2_adv;
  logic           s1_adv;
  logic           grant_any;
  logic [IDW-1:0] win;
  logic [IDW-1:0] ptr_next;
  logic           fire;

  // Stage advance conditions: S2 moves when empty or drained, S1 moves when
  // empty or S2 moves, so unload + transfer + load can all happen together.
  always_comb begin
    s2_adv = !rsp_valid || rsp_ready;
    s1_adv = !s1_valid || s2_adv;
  end

  // Round-robin search starting at rr_ptr; first asserted req_valid wins.
  always_comb begin
    int unsigned idx;
    grant_any = 1'b0;
    win       = '0;
    idx       = 0;
    for (int unsigned i = 0; i < NREQ; i++) begin
      idx = (32'(rr_ptr) + i) % NREQ;
      if (!grant_any && req_valid[idx]) begin
        grant_any = 1'b1;
        win       = IDW'(idx);
      end
    end
    ptr_next = IDW'((32'(win) + 1) % NREQ);
  end

  assign fire = grant_any && s1_adv;

  // One-hot accept on the winner, only in a cycle where S1 can take it;
  // forced low while reset is asserted.
  always_comb begin
    req_ready = '0;
    if (!rst && fire) begin
      req_ready[win] = 1'b1;
    end
  end

  // Arbitration pointer moves past the winner only on an actual grant.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rr_ptr <= '0;
    end else if (fire) begin
      rr_ptr <= ptr_next;
    end
  end

  // S1 operand register; operands hold their last values while S1 is empty.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      s1_valid <= 1'b0;
      s1_id    <= '0;
      mul_a    <= '0;
      mul_b    <= '0;
    end else if (s1_adv) begin
      s1_valid <= grant_any;
      if (grant_any) begin
        s1_id <= win;
        mul_a <= req_a[32'(win)*16 +: 16];
        mul_b <= req_b[32'(win)*16 +: 16];
      end
    end
  end

  // S2 result register captures the external product unmodified.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rsp_valid  <= 1'b0;
      rsp_id     <= '0;
      rsp_result <= '0;
    end else if (s2_adv) begin
      rsp_valid <= s1_valid;
      if (s1_valid) begin
        rsp_id     <= s1_id;
        rsp_result <= mul_result;
      end
    end
  end

  // Completed-response counter, wraps naturally at 16 bits.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ops_done <= '0;
    end else if (rsp_valid && rsp_ready) begin
      ops_done <= ops_done + 16'd1;
    end
  end

endmodule

// File: tb/tb_mult_share_ctrl.sv
// tb_mult_share_ctrl: randomized and directed stimulus for mult_share_ctrl,
// checked every cycle against a transaction-level model of the two slots.
module tb_mult_share_ctrl;

  logic        clk = 1'b0;
  logic        rst;
  logic [3:0]  req_valid;
  logic [3:0]  req_ready;
  logic [63:0] req_a;
  logic [63:0] req_b;
  logic [15:0] mul_a;
  logic [15:0] mul_b;
  logic [31:0] mul_result;
  logic        rsp_valid;
  logic        rsp_ready;
  logic [1:0]  rsp_id;
  logic [31:0] rsp_result;
  logic [15:0] ops_done;

  int checks = 0;
  int errors = 0;

  mult_share_ctrl #(.NREQ(4), .IDW(2)) dut (
    .clk(clk), .rst(rst), .req_valid(req_valid), .req_ready(req_ready),
    .req_a(req_a), .req_b(req_b), .mul_a(mul_a), .mul_b(mul_b),
    .mul_result(mul_result), .rsp_valid(rsp_valid), .rsp_ready(rsp_ready),
    .rsp_id(rsp_id), .rsp_result(rsp_result), .ops_done(ops_done)
  );

  // external combinational signed multiplier
  assign mul_result = $signed(mul_a) * $signed(mul_b);

  always #5 clk = ~clk;

  function automatic logic [31:0] golden(input logic [15:0] a, input logic [15:0] b);
    logic signed [31:0] p;
    p = $signed(a) * $signed(b);
    return p;
  endfunction

  function automatic int winner(input logic [3:0] v, input logic [1:0] ptr);
    for (int k = 0; k < 4; k++) begin
      int j;
      j = (int'(ptr) + k) % 4;
      if (v[j]) return j;
    end
    return -1;
  endfunction

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Model: each slot holds a transaction (requester id + operands).
  logic        m_s1v, m_s2v;
  logic [1:0]  m_s1id, m_s2id, m_ptr;
  logic [15:0] m_a, m_b;
  logic [31:0] m_res;
  logic [15:0] m_cnt;

  always @(posedge clk or posedge rst) begin
    bit s2adv, s1adv;
    int w;
    if (rst) begin
      m_s1v <= 1'b0; m_s2v <= 1'b0; m_s1id <= '0; m_s2id <= '0; m_ptr <= '0;
      m_a <= '0; m_b <= '0; m_res <= '0; m_cnt <= '0;
    end else begin
      s2adv = !m_s2v || rsp_ready;
      s1adv = !m_s1v || s2adv;
      w = winner(req_valid, m_ptr);
      if (m_s2v && rsp_ready) m_cnt <= m_cnt + 16'd1;
      if (s2adv) begin
        m_s2v <= m_s1v;
        if (m_s1v) begin
          m_s2id <= m_s1id;
          m_res  <= golden(m_a, m_b);
        end
      end
      if (s1adv) begin
        m_s1v <= (w >= 0);
        if (w >= 0) begin
          m_s1id <= 2'(w);
          m_a    <= req_a[w*16 +: 16];
          m_b    <= req_b[w*16 +: 16];
          m_ptr  <= 2'((w + 1) % 4);
        end
      end
    end
  end

  function automatic logic [3:0] exp_ready();
    bit s1adv;
    int w;
    if (rst) return 4'b0000;
    s1adv = !m_s1v || !m_s2v || rsp_ready;
    w = winner(req_valid, m_ptr);
    if (!s1adv || w < 0) return 4'b0000;
    return 4'(1 << w);
  endfunction

  // Per-cycle comparison against the model, away from the active edge.
  always @(negedge clk) begin
    chk("req_ready", 64'(req_ready), 64'(exp_ready()));
    chk("rsp_valid", 64'(rsp_valid), 64'(m_s2v));
    if (m_s2v) begin
      chk("rsp_id", 64'(rsp_id), 64'(m_s2id));
      chk("rsp_result", 64'(rsp_result), 64'(m_res));
    end
    chk("ops_done", 64'(ops_done), 64'(m_cnt));
    chk("mul_a", 64'(mul_a), 64'(m_a));
    chk("mul_b", 64'(mul_b), 64'(m_b));
  end

  // Record DUT handshakes for directed ordering checks.
  int          hs_count = 0;
  int          dut_grants[$];
  logic [33:0] dut_rsp[$];

  always @(posedge clk) begin
    if (!rst) begin
      if (rsp_valid && rsp_ready) begin
        hs_count <= hs_count + 1;
        dut_rsp.push_back({rsp_id, rsp_result});
      end
      for (int i = 0; i < 4; i++)
        if (req_valid[i] && req_ready[i]) dut_grants.push_back(i);
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    req_valid = '0;
    rsp_ready = 1'b0;
    step();
    step();
    rst = 1'b0;
  endtask

  initial begin
    int gs, rs, base, n0;
    logic [31:0] snap_res;
    logic [1:0]  snap_id;
    logic [15:0] snap_a, snap_b;

    rst = 1'b1; req_valid = '0; req_a = '0; req_b = '0; rsp_ready = 1'b0;
    #2;
    chk("reset_rsp_valid", 64'(rsp_valid), 64'd0);
    chk("reset_ops_done", 64'(ops_done), 64'd0);
    chk("reset_req_ready", 64'(req_ready), 64'd0);
    chk("reset_mul_a", 64'(mul_a), 64'd0);
    do_reset();

    // single request
    req_valid = 4'b0001; req_a[15:0] = 16'h0003; req_b[15:0] = 16'hFFFE; rsp_ready = 1'b1;
    step();
    req_valid = '0;
    step();
    chk("single_valid", 64'(rsp_valid), 64'd1);
    chk("single_id", 64'(rsp_id), 64'd0);
    chk("single_result", 64'(rsp_result), 64'hFFFF_FFFA);
    step();
    chk("single_ops_done", 64'(ops_done), 64'd1);

    // all four continuously: round-robin order and throughput
    do_reset();
    gs = dut_grants.size(); rs = dut_rsp.size();
    for (int i = 0; i < 4; i++) begin
      req_a[i*16 +: 16] = 16'(i * 16'h0101);
      req_b[i*16 +: 16] = 16'h0002;
    end
    req_valid = 4'b1111; rsp_ready = 1'b1;
    repeat (6) step();
    req_valid = '0;
    chk("rr_grant_count", 64'(dut_grants.size() - gs), 64'd6);
    if (dut_grants.size() - gs >= 5) begin
      chk("rr_g0", 64'(dut_grants[gs+0]), 64'd0);
      chk("rr_g1", 64'(dut_grants[gs+1]), 64'd1);
      chk("rr_g2", 64'(dut_grants[gs+2]), 64'd2);
      chk("rr_g3", 64'(dut_grants[gs+3]), 64'd3);
      chk("rr_g4", 64'(dut_grants[gs+4]), 64'd0);
    end
    chk("rr_rsp_count", 64'(dut_rsp.size() - rs), 64'd4);
    if (dut_rsp.size() - rs >= 4) begin
      chk("rr_r0", 64'(dut_rsp[rs+0]), 64'({2'd0, 32'h0000_0000}));
      chk("rr_r1", 64'(dut_rsp[rs+1]), 64'({2'd1, 32'h0000_0202}));
      chk("rr_r2", 64'(dut_rsp[rs+2]), 64'({2'd2, 32'h0000_0404}));
      chk("rr_r3", 64'(dut_rsp[rs+3]), 64'({2'd3, 32'h0000_0606}));
    end

    // corner operands
    do_reset();
    rs = dut_rsp.size();
    req_a[15:0] = 16'h8000; req_b[15:0] = 16'h8000;
    req_a[31:16] = 16'h7FFF; req_b[31:16] = 16'h8000;
    req_a[47:32] = 16'hFFFF; req_b[47:32] = 16'hFFFF;
    req_valid = 4'b0111; rsp_ready = 1'b1;
    repeat (3) step();
    req_valid = '0;
    repeat (3) step();
    chk("corner_count", 64'(dut_rsp.size() - rs), 64'd3);
    if (dut_rsp.size() - rs >= 3) begin
      chk("corner_0", 64'(dut_rsp[rs+0]), 64'({2'd0, 32'h4000_0000}));
      chk("corner_1", 64'(dut_rsp[rs+1]), 64'({2'd1, 32'hC000_8000}));
      chk("corner_2", 64'(dut_rsp[rs+2]), 64'({2'd2, 32'h0000_0001}));
    end

    // backpressure with both stages full
    do_reset();
    rs = dut_rsp.size();
    for (int i = 0; i < 4; i++) begin
      req_a[i*16 +: 16] = 16'(i + 5);
      req_b[i*16 +: 16] = 16'(i + 7);
    end
    req_valid = 4'b1111; rsp_ready = 1'b0;
    step(); step();
    snap_res = rsp_result; snap_id = rsp_id; snap_a = mul_a; snap_b = mul_b;
    for (int c = 0; c < 3; c++) begin
      step();
      chk("bp_valid", 64'(rsp_valid), 64'd1);
      chk("bp_result", 64'(rsp_result), 64'(snap_res));
      chk("bp_id", 64'(rsp_id), 64'(snap_id));
      chk("bp_ready", 64'(req_ready), 64'd0);
      chk("bp_mul_a", 64'(mul_a), 64'(snap_a));
      chk("bp_mul_b", 64'(mul_b), 64'(snap_b));
    end
    rsp_ready = 1'b1; req_valid = '0;
    repeat (3) step();
    chk("bp_drain_count", 64'(dut_rsp.size() - rs), 64'd2);
    if (dut_rsp.size() - rs >= 2) begin
      chk("bp_drain_0", 64'(dut_rsp[rs+0]), 64'({2'd0, 32'd35}));
      chk("bp_drain_1", 64'(dut_rsp[rs+1]), 64'({2'd1, 32'd48}));
    end

    // reset mid-stream
    do_reset();
    req_valid = 4'b1111; rsp_ready = 1'b1;
    repeat (4) step();
    rsp_ready = 1'b0;
    step(); step();
    chk("mid_ops_before", 64'(ops_done), 64'd2);
    chk("mid_full", 64'(rsp_valid), 64'd1);
    n0 = dut_rsp.size();
    rst = 1'b1;
    #1;
    chk("mid_rsp_valid", 64'(rsp_valid), 64'd0);
    chk("mid_ops_done", 64'(ops_done), 64'd0);
    chk("mid_req_ready", 64'(req_ready), 64'd0);
    chk("mid_mul_a", 64'(mul_a), 64'd0);
    step(); step();
    rst = 1'b0; req_valid = 4'b1010; rsp_ready = 1'b1;
    #1;
    chk("mid_first_ready", 64'(req_ready), 64'b0010);
    gs = dut_grants.size();
    step();
    chk("mid_no_rsp", 64'(dut_rsp.size()), 64'(n0));
    chk("mid_grant_count", 64'(dut_grants.size() - gs), 64'd1);
    if (dut_grants.size() > gs) chk("mid_first_grant", 64'(dut_grants[gs]), 64'd1);
    req_valid = '0;
    repeat (3) step();

    // randomized traffic
    do_reset();
    for (int c = 0; c < 1500; c++) begin
      req_valid = 4'($urandom);
      for (int i = 0; i < 4; i++) begin
        if ($urandom_range(0, 7) == 0) begin
          req_a[i*16 +: 16] = ($urandom_range(0, 1) != 0) ? 16'h8000 : 16'h7FFF;
          req_b[i*16 +: 16] = ($urandom_range(0, 1) != 0) ? 16'h8000 : 16'hFFFF;
        end else begin
          req_a[i*16 +: 16] = 16'($urandom);
          req_b[i*16 +: 16] = 16'($urandom);
        end
      end
      rsp_ready = ($urandom_range(0, 3) != 0);
      step();
    end
    req_valid = '0; rsp_ready = 1'b1;
    repeat (3) step();

    // counter wrap after 65536 handshakes
    do_reset();
    base = hs_count;
    req_valid = 4'b1111; rsp_ready = 1'b1;
    for (int c = 0; c < 70000; c++) begin
      step();
      if (hs_count - base >= 65536) break;
    end
    rsp_ready = 1'b0; req_valid = '0;
    chk("wrap_handshakes", 64'(hs_count - base), 64'd65536);
    chk("wrap_ops_done", 64'(ops_done), 64'h0000);
    step();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/mult_share_ctrl.md
MULT_SHARE_CTRL -- requirements
Module: mult_share_ctrl

Interface
REQ-001 SHALL have parameter: NREQ, 4, number of requesters sharing one 16x16 signed multiplier.
REQ-002 SHALL have parameter: IDW, 2, requester-ID width (clog2(NREQ)).
REQ-003 SHALL have one clock; reset is asynchronous and active-high.
REQ-004 Ports SHALL be as follows:
- clk  in  1  rising-edge clock.
- rst  in  1  asynchronous, active-high reset.
- req_valid  in  NREQ  per-requester operand valid.
- req_ready  out  NREQ  per-requester accept (one-hot or zero).
- req_a  in  NREQ*16  packed signed multiplicands; slice i belongs to requester i.
- req_b  in  NREQ*16  packed signed multipliers.
- mul_a  out  16  operand to the external combinational multiplier.
- mul_b  out  16  operand to the external multiplier.
- mul_result  in  32  signed product from the external multiplier, valid in the same cycle.
- rsp_valid  out  1  result valid.
- rsp_ready  in  1  result consumer accept.
- rsp_id  out  IDW  requester index of the result.
- rsp_result  out  32  signed product.
- ops_done  out  16  count of completed response handshakes.

Function
REQ-005 The request handshake SHALL occur on a rising edge where req_valid[i] and req_ready[i] are both high.
REQ-006 The response handshake SHALL occur on a rising edge where rsp_valid and rsp_ready are both high.
REQ-007 The pipeline SHALL have two stages:
- S1: operand register, driving mul_a/mul_b, with its own ID and valid.
- S2: result register, driving rsp_result/rsp_id/rsp_valid.
REQ-008 S2 SHALL advance (load or clear) when S2 is empty or rsp_ready is high.
REQ-009 S1 SHALL advance when S1 is empty or S2 advances.
REQ-010 req_ready SHALL be nonzero only when S1 advances.
REQ-011 When nonzero, req_ready SHALL be one-hot on the arbitration winner.
REQ-012 The controller SHALL grant at most one request per cycle.
REQ-013 Arbitration SHALL be round-robin:
- The search starts at pointer rr_ptr and proceeds rr_ptr, rr_ptr+1, ... modulo NREQ.
- The first asserted req_valid wins.
REQ-014 After a request handshake on winner w, rr_ptr SHALL become (w+1) mod NREQ.
REQ-015 rr_ptr SHALL hold its value when no grant occurs.
REQ-016 On an S1 load, mul_a/mul_b SHALL take req_a/req_b of the winner, and the S1 ID SHALL take w.
REQ-017 On an S2 load from a valid S1, S2 SHALL capture mul_result and the S1 ID.
REQ-018 The controller SHALL NOT modify operands or product: no sign-handling, truncation or saturation.
REQ-019 Latency SHALL be as follows:
- A request accepted on edge k yields rsp_valid high after edge k+1 when there is no backpressure.
- Throughput SHALL be one result per cycle.
REQ-020 While S2 is full and rsp_ready is low, S2 contents SHALL hold stable.
REQ-021 Under the same stall, S1 contents and mul_a/mul_b SHALL hold stable and req_ready SHALL be all zero if S1 is full.
REQ-022 When S1 is empty, mul_a/mul_b SHALL hold their last values.
REQ-023 A requester deasserting req_valid without a grant SHALL lose no state.
REQ-024 A requester SHALL NOT be granted twice for one handshake.
REQ-025 ops_done SHALL increment by 1 on each response handshake.
REQ-026 ops_done SHALL wrap from 0xFFFF to 0x0000.
REQ-027 Simultaneous S2 unload and S1 to S2 transfer and new S1 load in one cycle SHALL be supported with no bubble.

Reset
REQ-028 While rst is high, the following SHALL be 0 asynchronously: req_ready, rsp_valid, rsp_id, rsp_result, mul_a, mul_b, ops_done, rr_ptr, S1 valid and S1 ID.
REQ-029 Reset asserted mid-operation SHALL discard S1/S2 contents with no response emitted.
REQ-030 The first grant after reset release SHALL follow the pointer at 0.

Verification
REQ-031 Single request: req_valid=0001, req_a[0]=0x0003, req_b[0]=0xFFFE, rsp_ready=1 -> rsp_valid 2 edges after reset release plus grant edge, rsp_id=0, rsp_result=0xFFFFFFFA, ops_done=1.
REQ-032 All four valid continuously after reset, operands i*0x0101 x 0x0002 -> grants in order 0,1,2,3,0, one per cycle; results 0x00000000, 0x00000202, 0x00000404, 0x00000606 in ID order.
REQ-033 Corner operands 0x8000 x 0x8000 -> 0x40000000; 0x7FFF x 0x8000 -> 0xC0008000; 0xFFFF x 0xFFFF -> 0x00000001.
REQ-034 Backpressure: rsp_ready low for 3 cycles with S1 and S2 full -> rsp_result and rsp_id stable, req_ready=0000, mul_a/mul_b stable; then rsp_ready=1 -> results drain in order with no loss or duplication.
REQ-035 Reset mid-stream: assert rst with S1 and S2 full -> rsp_valid=0 immediately, ops_done=0; after release with req_valid=1010 -> requester 1 granted first.
REQ-036 Counter wrap: 65536 response handshakes -> ops_done reads 0x0000.
REQ-037 The bench SHALL compare every rsp_result against a signed 16x16 golden model.
